// File: rtl/sum_sq_pipe_pkg.sv
// Shared widths and latency for the sum-of-squares pipeline.
package sum_sq_pkg;
  localparam int unsigned WIDTH          = 16;
  localparam int unsigned BITS_PER_STAGE = 4;
  localparam int unsigned STAGES         = WIDTH / BITS_PER_STAGE;
  localparam int unsigned SQ_W           = 2 * WIDTH;
  localparam int unsigned RES_W          = 2 * WIDTH + 2;
  localparam int unsigned LATENCY        = STAGES + 2;
endpackage

// File: rtl/sum_sq_pipe_if.sv
// Argument/result bus of sum_sq_pipe: one valid-qualified triple in, one sum out.
interface sum_sq_pipe_if;
  import sum_sq_pkg::*;

  logic             arg_vld;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             res_vld;
  logic [RES_W-1:0] res;

  modport master (output arg_vld, a, b, c, input res_vld, res);
  modport slave  (input arg_vld, a, b, c, output res_vld, res);
endinterface

// File: rtl/sum_sq_pipe_isquare.sv
// Pipelined squarer: one B-bit digit of the multiplier per stage, latency W/B.
// Requires W/B >= 2.
module isquare
  import sum_sq_pkg::*;
#(
  parameter int unsigned W = WIDTH,
  parameter int unsigned B = BITS_PER_STAGE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           x_vld,
  input  logic [W-1:0]   x,
  output logic           y_vld,
  output logic [2*W-1:0] y
);
  localparam int unsigned NS = W / B;
  localparam int unsigned YW = 2 * W;

  logic [NS-1:0] r_vld;
  logic [W-1:0]  r_x   [NS-1];
  logic [YW-1:0] r_acc [NS];

  logic [NS-1:0] w_vin;
  logic [W-1:0]  w_xin   [NS];
  logic [YW-1:0] w_accin [NS];
  logic [YW-1:0] w_pp    [NS];

  // Stage inputs and the shifted partial product of each stage's digit.
  always_comb begin
    w_vin   = '0;
    w_xin   = '{default: '0};
    w_accin = '{default: '0};
    w_pp    = '{default: '0};
    w_vin[0]   = x_vld;
    w_xin[0]   = x;
    w_accin[0] = '0;
    for (int k = 1; k < int'(NS); k++) begin
      w_vin[k]   = r_vld[k-1];
      w_xin[k]   = r_x[k-1];
      w_accin[k] = r_acc[k-1];
    end
    for (int k = 0; k < int'(NS); k++) begin
      w_pp[k] = (YW'(w_xin[k]) * YW'(w_xin[k][k*B +: B])) << (k * B);
    end
  end

  // Valids always advance; data only loads when its incoming valid is set.
  always_ff @(posedge clk) begin
    if (!rst_n) r_vld <= '0;
    else        r_vld <= w_vin;
    for (int k = 0; k < int'(NS); k++) begin
      if (w_vin[k]) r_acc[k] <= w_accin[k] + w_pp[k];
    end
    for (int k = 0; k < int'(NS) - 1; k++) begin
      if (w_vin[k]) r_x[k] <= w_xin[k];
    end
  end

  assign y_vld = r_vld[NS-1];
  assign y     = r_acc[NS-1];
endmodule

// File: rtl/sum_sq_pipe.sv
// res = a*a + b*b + c*c: three pipelined squarers followed by a two-level registered adder tree.
module sum_sq_pipe
  import sum_sq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  sum_sq_pipe_if.slave  bus
);
  localparam int unsigned SAB_W = SQ_W + 1;

  logic            w_vld_a, w_vld_b, w_vld_c, w_s1_in;
  logic [SQ_W-1:0] w_sq_a, w_sq_b, w_sq_c;

  logic             r_s1_vld;
  logic [SAB_W-1:0] r_s_ab;
  logic [SQ_W-1:0]  r_s_c;
  logic             r_res_vld;
  logic [RES_W-1:0] r_res;

  isquare u_sq_a (.clk(clk), .rst_n(rst_n), .x_vld(bus.arg_vld), .x(bus.a), .y_vld(w_vld_a), .y(w_sq_a));
  isquare u_sq_b (.clk(clk), .rst_n(rst_n), .x_vld(bus.arg_vld), .x(bus.b), .y_vld(w_vld_b), .y(w_sq_b));
  isquare u_sq_c (.clk(clk), .rst_n(rst_n), .x_vld(bus.arg_vld), .x(bus.c), .y_vld(w_vld_c), .y(w_sq_c));

  assign w_s1_in = w_vld_a & w_vld_b & w_vld_c;

  // Adder level 1: pair a/b, carry c alongside.
  always_ff @(posedge clk) begin
    if (!rst_n) r_s1_vld <= 1'b0;
    else        r_s1_vld <= w_s1_in;
    if (w_s1_in) begin
      r_s_ab <= SAB_W'(w_sq_a) + SAB_W'(w_sq_b);
      r_s_c  <= w_sq_c;
    end
  end

  // Adder level 2: final sum; holds its last value through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_vld <= 1'b0;
      r_res     <= '0;
    end else begin
      r_res_vld <= r_s1_vld;
      if (r_s1_vld) r_res <= RES_W'(r_s_ab) + RES_W'(r_s_c);
    end
  end

  assign bus.res_vld = r_res_vld;
  assign bus.res     = r_res;
endmodule

// File: tb/tb_sum_sq_pipe.sv
// Self-checking bench for sum_sq_pipe plus a standalone 8-bit-digit isquare.
module tb_sum_sq_pipe;
  import sum_sq_pkg::*;

  typedef struct {
    int unsigned      due;
    logic [RES_W-1:0] val;
  } item_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sum_sq_pipe_if bus ();
  sum_sq_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic        sq_x_vld;
  logic [15:0] sq_x;
  logic        sq_y_vld;
  logic [31:0] sq_y;
  isquare #(.W(16), .B(8)) u_isq8 (
    .clk(clk), .rst_n(rst_n), .x_vld(sq_x_vld), .x(sq_x), .y_vld(sq_y_vld), .y(sq_y)
  );

  int unsigned      cyc = 0;
  int               checks = 0;
  int               errors = 0;
  item_t            sb[$];
  logic [RES_W-1:0] last_res = '0;

  function automatic logic [RES_W-1:0] ref_sum(input logic [15:0] xa, xb, xc);
    longint unsigned s;
    s = longint'(xa) * longint'(xa) + longint'(xb) * longint'(xb) + longint'(xc) * longint'(xc);
    return RES_W'(s);
  endfunction

  task automatic check_out();
    logic             exp_v;
    logic [RES_W-1:0] exp_r;
    exp_v = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_v    = 1'b1;
      last_res = sb[0].val;
      void'(sb.pop_front());
    end
    exp_r = last_res;
    checks++;
    assert (bus.res_vld === exp_v) else begin
      errors++;
      $error("FAIL res_vld cyc=%0d observed=%b expected=%b", cyc, bus.res_vld, exp_v);
    end
    checks++;
    assert (bus.res === exp_r) else begin
      errors++;
      $error("FAIL res cyc=%0d observed=0x%0h expected=0x%0h", cyc, bus.res, exp_r);
    end
  endtask

  // Present one cycle of inputs; an item presented in cycle t is due in cycle t+LATENCY.
  task automatic step(input logic rst, input logic v, input logic [15:0] xa, xb, xc);
    item_t it;
    rst_n       = rst;
    bus.arg_vld = v;
    bus.a       = xa;
    bus.b       = xb;
    bus.c       = xc;
    if (v && rst) begin
      it.due = cyc + LATENCY;
      it.val = ref_sum(xa, xb, xc);
      sb.push_back(it);
    end
    @(posedge clk);
    cyc++;
    if (!rst) begin
      sb.delete();
      last_res = '0;
    end
    #1;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.arg_vld = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.c       = '0;
    sq_x_vld    = 1'b0;
    sq_x        = '0;
    #1;

    step(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    step(1'b0, 1'b1, 16'd7, 16'd7, 16'd7);
    idle(3);

    step(1'b1, 1'b1, 16'd3, 16'd4, 16'd12);
    idle(LATENCY + 2);

    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step(1'b1, 1'b1, 16'd0, 16'd0, 16'd0);
    step(1'b1, 1'b1, 16'd1, 16'd0, 16'hFFFF);
    idle(LATENCY + 2);

    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    idle(LATENCY + 2);

    begin
      logic [5:0] pat;
      pat = 6'b101001;
      for (int i = 0; i < 6; i++) step(1'b1, pat[i], 16'($urandom), 16'($urandom), 16'($urandom));
    end
    idle(LATENCY + 2);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    step(1'b0, 1'b1, 16'd9, 16'd9, 16'd9);
    idle(LATENCY + 2);
    step(1'b1, 1'b1, 16'd1000, 16'd2000, 16'd3000);
    idle(LATENCY + 2);

    sq_x_vld = 1'b1;
    sq_x     = 16'd40000;
    step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
    sq_x_vld = 1'b0;
    sq_x     = 16'd123;
    checks++;
    assert (sq_y_vld === 1'b0) else begin
      errors++;
      $error("FAIL isq8_vld_early observed=%b expected=0", sq_y_vld);
    end
    step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
    checks++;
    assert (sq_y_vld === 1'b1) else begin
      errors++;
      $error("FAIL isq8_vld observed=%b expected=1", sq_y_vld);
    end
    checks++;
    assert (sq_y === 32'(64'd40000 * 64'd40000)) else begin
      errors++;
      $error("FAIL isq8_y observed=%0d expected=%0d", sq_y, 32'(64'd40000 * 64'd40000));
    end
    step(1'b1, 1'b0, 16'd0, 16'd0, 16'd0);
    checks++;
    assert (sq_y_vld === 1'b0) else begin
      errors++;
      $error("FAIL isq8_vld_late observed=%b expected=0", sq_y_vld);
    end

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
